// File: rtl/zoom_hdmi_pkg.sv
// Shared definitions for the zoom-to-HDMI read side.
// Contents:
//   - Video timing presets (720p60, 1080p60) as per-axis constant sets.
//   - Pixel width and default border colour.
//   - Reader FSM state encodings.
//   - A helper for window span tests.
package zoom_hdmi_pkg;

  localparam int c_PIXEL_WIDTH = 24;
  localparam int c_CNT_WIDTH   = 12;
  localparam int c_WIN_WIDTH   = 12;

  localparam logic [c_PIXEL_WIDTH-1:0] c_BORDER_DEFAULT = 24'h000000;

  // One axis of a video mode: active, front porch, sync, back porch.
  typedef struct packed {
    logic [c_CNT_WIDTH-1:0] active;
    logic [c_CNT_WIDTH-1:0] fp;
    logic [c_CNT_WIDTH-1:0] sync;
    logic [c_CNT_WIDTH-1:0] bp;
  } timing_axis_t;

  localparam timing_axis_t c_720P60_H  = '{active: 12'd1280, fp: 12'd110, sync: 12'd40, bp: 12'd220};
  localparam timing_axis_t c_720P60_V  = '{active: 12'd720,  fp: 12'd5,   sync: 12'd5,  bp: 12'd20};
  localparam timing_axis_t c_1080P60_H = '{active: 12'd1920, fp: 12'd88,  sync: 12'd44, bp: 12'd148};
  localparam timing_axis_t c_1080P60_V = '{active: 12'd1080, fp: 12'd4,   sync: 12'd5,  bp: 12'd36};

  // Reader FSM encodings.
  localparam logic [0:0] ST_PREFILL = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  // True when org <= pos < org + len. Evaluated at 13 bits so the end of a
  // window near the top of the 12-bit range never wraps back to zero.
  function automatic logic in_span(input logic [c_WIN_WIDTH-1:0] pos,
                                   input logic [c_WIN_WIDTH-1:0] org,
                                   input logic [c_WIN_WIDTH-1:0] len);
    logic [c_WIN_WIDTH:0] p;
    logic [c_WIN_WIDTH:0] lo;
    logic [c_WIN_WIDTH:0] hi;
    p  = {1'b0, pos};
    lo = {1'b0, org};
    hi = {1'b0, org} + {1'b0, len};
    return (p >= lo) && (p < hi);
  endfunction

endpackage

// File: rtl/zoom_hdmi_timing_gen.sv
// Raster counters and stage-0 video timing.
// Ports:
//   clk, rst     pixel clock, async active-high reset
//   hcnt, vcnt   pixel / line counters (wrap unconditionally)
//   de0          inside active area
//   hs0, vs0     inside sync interval (active-high here; polarity applied later)
//   frame_start  high while hcnt == 0 and vcnt == 0
module zoom_hdmi_timing_gen
  import zoom_hdmi_pkg::*;
#(
  parameter int c_H_ACTIVE = 1280,
  parameter int c_H_FP     = 110,
  parameter int c_H_SYNC   = 40,
  parameter int c_H_BP     = 220,
  parameter int c_V_ACTIVE = 720,
  parameter int c_V_FP     = 5,
  parameter int c_V_SYNC   = 5,
  parameter int c_V_BP     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [c_CNT_WIDTH-1:0] hcnt,
  output logic [c_CNT_WIDTH-1:0] vcnt,
  output logic                   de0,
  output logic                   hs0,
  output logic                   vs0,
  output logic                   frame_start
);

  localparam int c_H_TOTAL = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
  localparam int c_V_TOTAL = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

  localparam logic [c_CNT_WIDTH-1:0] c_H_LAST   = c_CNT_WIDTH'(c_H_TOTAL - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_V_LAST   = c_CNT_WIDTH'(c_V_TOTAL - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_H_ACT    = c_CNT_WIDTH'(c_H_ACTIVE);
  localparam logic [c_CNT_WIDTH-1:0] c_V_ACT    = c_CNT_WIDTH'(c_V_ACTIVE);
  localparam logic [c_CNT_WIDTH-1:0] c_HS_START = c_CNT_WIDTH'(c_H_ACTIVE + c_H_FP);
  localparam logic [c_CNT_WIDTH-1:0] c_HS_END   = c_CNT_WIDTH'(c_H_ACTIVE + c_H_FP + c_H_SYNC);
  localparam logic [c_CNT_WIDTH-1:0] c_VS_START = c_CNT_WIDTH'(c_V_ACTIVE + c_V_FP);
  localparam logic [c_CNT_WIDTH-1:0] c_VS_END   = c_CNT_WIDTH'(c_V_ACTIVE + c_V_FP + c_V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == c_H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == c_V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign de0         = (hcnt < c_H_ACT) && (vcnt < c_V_ACT);
  assign hs0         = (hcnt >= c_HS_START) && (hcnt < c_HS_END);
  assign vs0         = (vcnt >= c_VS_START) && (vcnt < c_VS_END);
  assign frame_start = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/zoom_hdmi_fifo_reader.sv
// Read side of the zoom-to-HDMI FIFO, in the pixel clock domain.
// Generates HDMI timing, pops pixels only inside a per-frame zoom window,
// fills the rest of the active area with border_color, and after an
// underflow discards the owed words during blanking so the next frame
// starts aligned.
// Ports:
//   rd_clk, rd_rst              pixel clock, async active-high reset
//   fifo_rd_data/empty/level    FIFO read side (data valid 1 cycle after pop)
//   fifo_rd_en                  FIFO pop (combinational from counter stage)
//   win_x0/y0/w/h               zoom window, taken at frame start
//   border_color                fill colour
//   vid_hs/vs/de/data           registered video, 2 cycles after counters
//   frame_start                 counter-stage pulse at h=0, v=0
//   underflow                   sticky missed-pixel flag
//   deficit                     words owed to the FIFO
//
// state   | meaning
// PREFILL | waiting for the FIFO to reach c_PREFILL; window shows border
// RUN     | popping window pixels and draining owed words in blanking
module zoom_hdmi_fifo_reader
  import zoom_hdmi_pkg::*;
#(
  parameter int c_H_ACTIVE    = int'(c_720P60_H.active),
  parameter int c_H_FP        = int'(c_720P60_H.fp),
  parameter int c_H_SYNC      = int'(c_720P60_H.sync),
  parameter int c_H_BP        = int'(c_720P60_H.bp),
  parameter int c_V_ACTIVE    = int'(c_720P60_V.active),
  parameter int c_V_FP        = int'(c_720P60_V.fp),
  parameter int c_V_SYNC      = int'(c_720P60_V.sync),
  parameter int c_V_BP        = int'(c_720P60_V.bp),
  parameter int c_HS_POL      = 1,
  parameter int c_VS_POL      = 1,
  parameter int c_DATA_WIDTH  = c_PIXEL_WIDTH,
  parameter int c_LEVEL_WIDTH = 9,
  parameter int c_PREFILL     = 128
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [c_DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                     fifo_rd_empty,
  input  logic [c_LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                     fifo_rd_en,
  input  logic [c_WIN_WIDTH-1:0]   win_x0,
  input  logic [c_WIN_WIDTH-1:0]   win_y0,
  input  logic [c_WIN_WIDTH-1:0]   win_w,
  input  logic [c_WIN_WIDTH-1:0]   win_h,
  input  logic [c_DATA_WIDTH-1:0]  border_color,
  output logic                     vid_hs,
  output logic                     vid_vs,
  output logic                     vid_de,
  output logic [c_DATA_WIDTH-1:0]  vid_data,
  output logic                     frame_start,
  output logic                     underflow,
  output logic [23:0]              deficit
);

  localparam logic c_HS_ON = (c_HS_POL != 0);
  localparam logic c_VS_ON = (c_VS_POL != 0);
  localparam logic [c_LEVEL_WIDTH-1:0] c_PREFILL_LVL = c_LEVEL_WIDTH'(c_PREFILL);
  localparam logic [23:0] c_DEFICIT_MAX = '1;

  // Counter stage
  logic [c_CNT_WIDTH-1:0] hcnt;
  logic [c_CNT_WIDTH-1:0] vcnt;
  logic                   de0;
  logic                   hs0;
  logic                   vs0;

  zoom_hdmi_timing_gen #(
    .c_H_ACTIVE (c_H_ACTIVE),
    .c_H_FP     (c_H_FP),
    .c_H_SYNC   (c_H_SYNC),
    .c_H_BP     (c_H_BP),
    .c_V_ACTIVE (c_V_ACTIVE),
    .c_V_FP     (c_V_FP),
    .c_V_SYNC   (c_V_SYNC),
    .c_V_BP     (c_V_BP)
  ) u_timing (
    .clk         (rd_clk),
    .rst         (rd_rst),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .de0         (de0),
    .hs0         (hs0),
    .vs0         (vs0),
    .frame_start (frame_start)
  );

  // Per-frame window and run latch
  logic [c_WIN_WIDTH-1:0] x0_q;
  logic [c_WIN_WIDTH-1:0] y0_q;
  logic [c_WIN_WIDTH-1:0] w_q;
  logic [c_WIN_WIDTH-1:0] h_q;
  logic                   run_q;
  logic [0:0]             state;

  logic [c_WIN_WIDTH-1:0] x0_e;
  logic [c_WIN_WIDTH-1:0] y0_e;
  logic [c_WIN_WIDTH-1:0] w_e;
  logic [c_WIN_WIDTH-1:0] h_e;
  logic                   run_frame;

  // The frame-start pixel itself already belongs to the new frame, so it
  // sees the live inputs; every later pixel uses the values latched there.
  // Whether a frame pops is fixed by the state at its start, so the frame
  // during which PREFILL completes is shown entirely as border.
  always_comb begin
    x0_e      = x0_q;
    y0_e      = y0_q;
    w_e       = w_q;
    h_e       = h_q;
    run_frame = run_q;
    if (frame_start) begin
      x0_e      = win_x0;
      y0_e      = win_y0;
      w_e       = win_w;
      h_e       = win_h;
      run_frame = (state == ST_RUN);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      x0_q  <= '0;
      y0_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      run_q <= 1'b0;
    end else if (frame_start) begin
      x0_q  <= win_x0;
      y0_q  <= win_y0;
      w_q   <= win_w;
      h_q   <= win_h;
      run_q <= (state == ST_RUN);
    end
  end

  // Window test and pop decisions; de0 clips windows that overhang the
  // active area, and a zero width or height never matches.
  logic win0;
  logic pop_win;
  logic miss;
  logic pop_drain;

  assign win0      = de0 && in_span(hcnt, x0_e, w_e) && in_span(vcnt, y0_e, h_e);
  assign pop_win   = run_frame && win0 && !fifo_rd_empty;
  assign miss      = run_frame && win0 && fifo_rd_empty;
  assign pop_drain = (state == ST_RUN) && !de0 && (deficit != '0) && !fifo_rd_empty;
  assign fifo_rd_en = pop_win || pop_drain;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= ST_PREFILL;
    end else begin
      case (state)
        ST_PREFILL: if (frame_start && (fifo_rd_water_level >= c_PREFILL_LVL)) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  // miss only happens inside de0 and drain only outside it, so the two
  // branches never compete.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      deficit   <= '0;
      underflow <= 1'b0;
    end else if (miss) begin
      underflow <= 1'b1;
      if (deficit != c_DEFICIT_MAX) deficit <= deficit + 1'b1;
    end else if (pop_drain) begin
      deficit <= deficit - 1'b1;
    end
  end

  // Stage 1: timing plus pop flag, aligned with fifo_rd_data
  logic hs1;
  logic vs1;
  logic de1;
  logic win1;
  logic popped1;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      de1     <= 1'b0;
      win1    <= 1'b0;
      popped1 <= 1'b0;
    end else begin
      hs1     <= hs0;
      vs1     <= vs0;
      de1     <= de0;
      win1    <= win0;
      popped1 <= pop_win;
    end
  end

  // Stage 2: output registers. Drained words never set popped1, so they
  // cannot reach vid_data.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vid_hs   <= ~c_HS_ON;
      vid_vs   <= ~c_VS_ON;
      vid_de   <= 1'b0;
      vid_data <= '0;
    end else begin
      vid_hs <= hs1 ? c_HS_ON : ~c_HS_ON;
      vid_vs <= vs1 ? c_VS_ON : ~c_VS_ON;
      vid_de <= de1;
      if (win1 && popped1) begin
        vid_data <= fifo_rd_data;
      end else if (de1) begin
        vid_data <= border_color;
      end else begin
        vid_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_zoom_hdmi_fifo_reader.sv
module tb_zoom_hdmi_fifo_reader;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int PREFILL = 128;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic [23:0] fifo_rd_data = '0;
  logic        fifo_rd_empty;
  logic [8:0]  fifo_rd_water_level;
  logic        fifo_rd_en;
  logic [11:0] win_x0 = '0, win_y0 = '0, win_w = '0, win_h = '0;
  logic [23:0] border_color = '0;
  logic        vid_hs, vid_vs, vid_de;
  logic [23:0] vid_data;
  logic        frame_start, underflow;
  logic [23:0] deficit;

  zoom_hdmi_fifo_reader #(
    .c_H_ACTIVE(HA), .c_H_FP(HF), .c_H_SYNC(HS), .c_H_BP(HB),
    .c_V_ACTIVE(VA), .c_V_FP(VF), .c_V_SYNC(VS), .c_V_BP(VB),
    .c_HS_POL(1), .c_VS_POL(1), .c_DATA_WIDTH(24), .c_LEVEL_WIDTH(9),
    .c_PREFILL(PREFILL)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .border_color(border_color),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
    .frame_start(frame_start), .underflow(underflow), .deficit(deficit)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: words are 0xA00000 + index; starve forces empty
  logic [23:0] mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  logic starve = 1'b0;

  assign fifo_rd_empty = starve || (wr_ptr == rd_ptr);
  assign fifo_rd_water_level = ((wr_ptr - rd_ptr) > 256) ? 9'd256 : 9'(wr_ptr - rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = 24'(32'hA00000 + wr_ptr);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Reference model and scoreboard
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] data;
  } pix_t;

  pix_t  sb[$];
  int    m_h, m_v, m_x0, m_y0, m_w, m_h_win, m_def;
  bit    m_state, m_run, m_uf;
  int    sb_err = 0;
  string sb_msg = "";
  int    hs_cnt, vs_cnt, de_cnt, bord_cnt, blank_nz_cnt;
  int    passed = 0;
  int    total = 0;

  task automatic model_reset();
    m_h = 0; m_v = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_h_win = 0; m_def = 0;
    m_state = 0; m_run = 0; m_uf = 0;
    sb.delete();
    sb.push_back(pix_t'{1'b0, 1'b0, 1'b0, 24'h0});
    sb.push_back(pix_t'{1'b0, 1'b0, 1'b0, 24'h0});
  endtask

  task automatic clear_counts();
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; bord_cnt = 0; blank_nz_cnt = 0;
  endtask

  // Runs n cycles starting at a negedge; records scoreboard mismatches
  task automatic advance(input int n);
    pix_t got, exp;
    bit   de0, hs0, vs0, fs, win0, pw, miss, drain, run_f;
    int   x0, y0, w, h;
    for (int i = 0; i < n; i++) begin
      #1;
      got = '{vid_hs, vid_vs, vid_de, vid_data};
      exp = sb.pop_front();
      if (got !== exp) begin
        if (sb_err == 0) sb_msg = $sformatf("vid at h=%0d v=%0d got %h want %h", m_h, m_v, got, exp);
        sb_err++;
      end
      if (deficit !== 24'(m_def) || underflow !== m_uf) begin
        if (sb_err == 0) sb_msg = $sformatf("deficit/underflow got %0d/%b want %0d/%b", deficit, underflow, m_def, m_uf);
        sb_err++;
      end
      hs_cnt += int'(got.hs);
      vs_cnt += int'(got.vs);
      de_cnt += int'(got.de);
      if (got.de && got.data == border_color) bord_cnt++;
      if (!got.de && got.data != 0) blank_nz_cnt++;

      fs  = (m_h == 0) && (m_v == 0);
      de0 = (m_h < HA) && (m_v < VA);
      hs0 = (m_h >= HA + HF) && (m_h < HA + HF + HS);
      vs0 = (m_v >= VA + VF) && (m_v < VA + VF + VS);
      if (fs) begin
        x0 = int'(win_x0); y0 = int'(win_y0); w = int'(win_w); h = int'(win_h); run_f = m_state;
      end else begin
        x0 = m_x0; y0 = m_y0; w = m_w; h = m_h_win; run_f = m_run;
      end
      win0  = de0 && (m_h >= x0) && (m_h < x0 + w) && (m_v >= y0) && (m_v < y0 + h);
      pw    = run_f && win0 && !fifo_rd_empty;
      miss  = run_f && win0 && fifo_rd_empty;
      drain = m_state && !de0 && (m_def > 0) && !fifo_rd_empty;
      if (frame_start !== fs || fifo_rd_en !== (pw || drain)) begin
        if (sb_err == 0) sb_msg = $sformatf("h=%0d v=%0d frame_start %b/%b rd_en %b/%b", m_h, m_v, frame_start, fs, fifo_rd_en, pw || drain);
        sb_err++;
      end
      exp.hs = hs0; exp.vs = vs0; exp.de = de0;
      exp.data = pw ? mem[rd_ptr % 1024] : (de0 ? border_color : 24'h0);
      sb.push_back(exp);

      if (fs) begin
        m_x0 = x0; m_y0 = y0; m_w = w; m_h_win = h; m_run = m_state;
        if (int'(fifo_rd_water_level) >= PREFILL) m_state = 1;
      end
      if (miss) begin
        if (m_def < 24'hFFFFFF) m_def++;
        m_uf = 1;
      end else if (drain) begin
        m_def--;
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
      @(negedge rd_clk);
    end
  endtask

  task automatic set_window(input int x, input int y, input int w, input int h);
    win_x0 = 12'(x); win_y0 = 12'(y); win_w = 12'(w); win_h = 12'(h);
  endtask

  task automatic test_reset();
    push_words(200);
    set_window(0, 0, 8, 4);
    border_color = 24'h00FF00;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    @(negedge rd_clk);
    total++; if (vid_hs !== 1'b0) $display("FAIL reset_hs got %b want 0", vid_hs); else passed++;
    total++; if (vid_vs !== 1'b0) $display("FAIL reset_vs got %b want 0", vid_vs); else passed++;
    total++; if (vid_de !== 1'b0) $display("FAIL reset_de got %b want 0", vid_de); else passed++;
    total++; if (vid_data !== 24'h0) $display("FAIL reset_data got %h want 0", vid_data); else passed++;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); else passed++;
    total++; if (underflow !== 1'b0 || deficit !== 24'h0) $display("FAIL reset_flags got %b/%0d want 0/0", underflow, deficit); else passed++;
    model_reset();
    rd_rst = 1'b0;
  endtask

  task automatic test_prefill_frames();
    int r0, e0;
    e0 = sb_err;
    r0 = rd_ptr; clear_counts();
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 0) $display("FAIL prefill_pops got %0d want 0", rd_ptr - r0); else passed++;
    total++; if (hs_cnt !== 14) $display("FAIL hs_width got %0d want 14", hs_cnt); else passed++;
    total++; if (vs_cnt !== 14) $display("FAIL vs_width got %0d want 14", vs_cnt); else passed++;
    total++; if (de_cnt !== 32 || bord_cnt !== 32) $display("FAIL frame1_border got de=%0d border=%0d want 32/32", de_cnt, bord_cnt); else passed++;
    r0 = rd_ptr; clear_counts();
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 32) $display("FAIL frame2_pops got %0d want 32", rd_ptr - r0); else passed++;
    total++; if (bord_cnt !== 0) $display("FAIL frame2_border got %0d want 0", bord_cnt); else passed++;
    total++; if (sb_err !== e0) $display("FAIL prefill_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  task automatic test_window();
    int r0, e0;
    e0 = sb_err;
    set_window(2, 1, 3, 2);
    border_color = 24'hFF0000;
    r0 = rd_ptr; clear_counts();
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 6) $display("FAIL window_pops got %0d want 6", rd_ptr - r0); else passed++;
    total++; if (bord_cnt !== 26) $display("FAIL window_border got %0d want 26", bord_cnt); else passed++;
    total++; if (blank_nz_cnt !== 0) $display("FAIL blank_zero got %0d nonzero want 0", blank_nz_cnt); else passed++;
    total++; if (sb_err !== e0) $display("FAIL window_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  task automatic test_underflow();
    int r0, e0;
    e0 = sb_err;
    r0 = rd_ptr; clear_counts();
    starve = 1'b1;
    advance(19);
    starve = 1'b0;
    push_words(3);
    advance(3);
    total++; if (deficit !== 24'd3) $display("FAIL uf_deficit got %0d want 3", deficit); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL uf_flag got %b want 1", underflow); else passed++;
    total++; if (rd_ptr - r0 !== 0) $display("FAIL uf_no_pop got %0d want 0", rd_ptr - r0); else passed++;
    advance(FRAME - 22);
    total++; if (rd_ptr - r0 !== 6) $display("FAIL uf_drain_pops got %0d want 6", rd_ptr - r0); else passed++;
    total++; if (deficit !== 24'd0) $display("FAIL uf_deficit_clear got %0d want 0", deficit); else passed++;
    total++; if (bord_cnt !== 29) $display("FAIL uf_border got %0d want 29", bord_cnt); else passed++;
    r0 = rd_ptr;
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 6) $display("FAIL uf_next_pops got %0d want 6", rd_ptr - r0); else passed++;
    total++; if (sb_err !== e0) $display("FAIL uf_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  task automatic test_window_change();
    int r0, e0;
    e0 = sb_err;
    r0 = rd_ptr;
    advance(10);
    win_x0 = 12'd6;
    advance(FRAME - 10);
    total++; if (rd_ptr - r0 !== 6) $display("FAIL chg_current_pops got %0d want 6", rd_ptr - r0); else passed++;
    r0 = rd_ptr;
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 4) $display("FAIL chg_next_pops got %0d want 4", rd_ptr - r0); else passed++;
    total++; if (sb_err !== e0) $display("FAIL chg_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  task automatic test_clip();
    int r0, e0;
    e0 = sb_err;
    set_window(6, 0, 10, 1);
    r0 = rd_ptr;
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 2) $display("FAIL clip_pops got %0d want 2", rd_ptr - r0); else passed++;
    total++; if (sb_err !== e0) $display("FAIL clip_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  task automatic test_reset_mid();
    int r0, e0;
    e0 = sb_err;
    advance(20);
    total++; if (underflow !== 1'b1) $display("FAIL mid_pre_uf got %b want 1", underflow); else passed++;
    #2;
    rd_rst = 1'b1;
    #1;
    total++; if (vid_hs !== 1'b0 || vid_vs !== 1'b0 || vid_de !== 1'b0) $display("FAIL mid_timing got %b%b%b want 000", vid_hs, vid_vs, vid_de); else passed++;
    total++; if (vid_data !== 24'h0) $display("FAIL mid_data got %h want 0", vid_data); else passed++;
    total++; if (underflow !== 1'b0 || deficit !== 24'h0) $display("FAIL mid_flags got %b/%0d want 0/0", underflow, deficit); else passed++;
    total++; if (fifo_rd_en !== 1'b0) $display("FAIL mid_rd_en got %b want 0", fifo_rd_en); else passed++;
    @(negedge rd_clk);
    @(negedge rd_clk);
    model_reset();
    rd_rst = 1'b0;
    r0 = rd_ptr;
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 0) $display("FAIL mid_prefill_pops got %0d want 0", rd_ptr - r0); else passed++;
    r0 = rd_ptr;
    advance(FRAME);
    total++; if (rd_ptr - r0 !== 2) $display("FAIL mid_run_pops got %0d want 2", rd_ptr - r0); else passed++;
    total++; if (sb_err !== e0) $display("FAIL mid_scoreboard errors %0d want %0d: %s", sb_err, e0, sb_msg); else passed++;
  endtask

  initial begin
    test_reset();
    test_prefill_frames();
    test_window();
    test_underflow();
    test_window_change();
    test_clip();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zoom_hdmi_fifo_reader.md
Name: zoom_hdmi_fifo_reader

Overview:
Downstream consumer of the 24-bit x 256-deep zoom-to-HDMI FIFO, running in the HDMI pixel clock domain (the FIFO read side).
- Generates HDMI video timing: hsync, vsync, de.
- Pops pixels from the FIFO only inside a runtime zoom window and fills the rest of the active area with a border colour.
- Recovers frame alignment after FIFO underflow by discarding owed words during blanking.

Parameters:
c_H_ACTIVE, 1280, active pixels per line
c_H_FP, 110, horizontal front porch
c_H_SYNC, 40, hsync width
c_H_BP, 220, horizontal back porch
c_V_ACTIVE, 720, active lines
c_V_FP, 5, vertical front porch
c_V_SYNC, 5, vsync width
c_V_BP, 20, vertical back porch
c_HS_POL, 1, hsync active level
c_VS_POL, 1, vsync active level
c_DATA_WIDTH, 24, pixel width (RGB888)
c_LEVEL_WIDTH, 9, FIFO water-level width (depth width + 1)
c_PREFILL, 128, FIFO words required before the first frame is shown

Ports:
rd_clk  in  1  pixel clock, same as the FIFO read clock
rd_rst  in  1  reset, asynchronous, active-high
fifo_rd_data  in  c_DATA_WIDTH  FIFO read data; valid 1 cycle after fifo_rd_en (no output register)
fifo_rd_empty  in  1  FIFO empty
fifo_rd_water_level  in  c_LEVEL_WIDTH  FIFO fill level
fifo_rd_en  out  1  FIFO pop
win_x0, win_y0, win_w, win_h  in  12 each  zoom window origin and size; sampled at frame start
border_color  in  c_DATA_WIDTH  fill colour outside the window, or when no data is available
vid_hs, vid_vs, vid_de  out  1 each  registered video timing
vid_data  out  c_DATA_WIDTH  registered pixel
frame_start  out  1  one-cycle pulse at h=0, v=0 (counter stage)
underflow  out  1  sticky; set on any missed window pixel; cleared only by rd_rst
deficit  out  24  words owed to the FIFO (debug)

Behaviour:
- Reset values:
  - hcnt, vcnt = 0; state = PREFILL; deficit = 0; underflow = 0; fifo_rd_en = 0.
  - vid_hs = !c_HS_POL, vid_vs = !c_VS_POL, vid_de = 0, vid_data = 0.
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = active + FP + SYNC + BP.
  - vcnt increments when hcnt wraps and runs 0..V_TOTAL-1.
  - Counters wrap unconditionally.
- Stage-0 timing:
  - de0 = hcnt < c_H_ACTIVE && vcnt < c_V_ACTIVE.
  - hs0 is active for hcnt in [c_H_ACTIVE + c_H_FP, c_H_ACTIVE + c_H_FP + c_H_SYNC).
  - vs0 is active for vcnt in the equivalent vertical range, for the whole line.
- Window latch: at hcnt == 0 && vcnt == 0, latch the four win_* inputs.
- Window test: win0 = de0 && hcnt >= x0 && hcnt < x0 + w && vcnt >= y0 && vcnt < y0 + h.
  - Sums are computed at 13 bits, so no wrap occurs.
  - w == 0 or h == 0 means the window is empty.
  - A window extending past the active area is clipped by de0.
- State machine:
  - PREFILL: never pops; the window shows border_color. Go to RUN at frame start when fifo_rd_water_level >= c_PREFILL.
  - RUN: never leaves RUN except via reset.
- Pops in RUN (fifo_rd_en is combinational from stage 0):
  - Window pixel with FIFO not empty: pop.
  - Window pixel with FIFO empty: no pop; deficit += 1 (saturating at 2^24-1); underflow <= 1.
  - Outside de0 with deficit > 0 and FIFO not empty: pop and discard; deficit -= 1.
  - Increment and decrement cannot coincide (window vs blanking), so no simultaneity case exists.
- Pipeline:
  - Stage 1 registers hs, vs, de, win and a popped flag.
  - Stage 2 output registers:
    - vid_data = fifo_rd_data if stage-1 win && popped;
    - vid_data = border_color if de1 otherwise;
    - vid_data = 0 when !de1.
  - Total latency from counters to vid_* is 2 cycles, with all timing outputs aligned.
  - Discarded words never reach vid_data.
- Reset mid-frame: everything returns to reset values immediately and restarts in PREFILL; FIFO contents are not flushed by this block.

Decomposition:
- Shared package (zoom_hdmi_pkg): timing presets (720p60, 1080p60) as constant sets; pixel width constant; border default.
- One sub-module, natural to split out: zoom_hdmi_timing_gen (hcnt/vcnt, de0/hs0/vs0, frame_start).
- Window logic, the state machine, deficit tracking and the output pipeline stay in the top module.

Test Plan:
1. Small timing (active 8x4, porches 2/2/2 and 1/1/1), FIFO pre-loaded with 200 words, c_PREFILL = 128, window 0,0,8,4 -> first frame border only; second frame shows 32 sequential words; vid_* lag counters by exactly 2 cycles; hs/vs widths are 2 and 1.
2. Window 2,1,3,2 with border 0xFF0000 -> 6 pops per frame; pixel (2..4, 1..2) carries data; other active pixels are 0xFF0000; blanking pixels are 0.
3. FIFO empty for 3 window pixels in RUN -> those pixels show the border; underflow = 1; deficit = 3. After refill, exactly 3 pops occur in the next blanking with data discarded; deficit = 0; the following frame is aligned.
4. win_x0 changed mid-frame -> current frame unchanged; new window applied from the next frame_start.
5. Window 6,0,10,1 with active width 8 -> clipped to 2 pops per frame; no pops outside de.
6. rd_rst asserted mid-line -> all outputs at reset values within the same cycle (async); state PREFILL; underflow cleared.
